// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch controller
// Purpose: instruction width, PC increment, fetch-queue entry type and FSM state type.
// Ports: none (package).
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO of fetched {pc, instr} entries
// Purpose: holds fetched instructions between the PC logic and decode.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears storage)
//   flush         drop all entries (wins over push/pop)
//   push, push_entry   enqueue one entry (caller guarantees space or a same-cycle pop)
//   pop           dequeue the head (caller guarantees non-empty)
//   head          entry at the read pointer
//   count         current occupancy, 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fq_entry_t                push_entry,
  input  logic                     pop,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       cnt_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_entry;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch controller: PC, fetch FSM, redirect and halt handling
// Purpose: fetches one word per cycle from a combinational imem into fetch_queue and
//   presents it to decode with a valid/ready handshake.
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirects
//   (sticky misalign_err, FSM held in HALT until an aligned redirect).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_addr / imem_data     instruction memory byte address (= PC) / returned word
//   redirect_valid/_pc        flush + new PC from execute
//   halt                      level request to stop fetching
//   out_valid/_instr/_pc/_ready   decode handshake on the queue head
//   fq_count                  queue occupancy
//   misalign_err              sticky misaligned-redirect flag (0 when feature disabled)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  output logic [$clog2(FQ_DEPTH):0]  fq_count,
  output logic                       misalign_err
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pop, push;
  logic         misaligned;
  logic         lock;
  fq_entry_t    head, push_entry;

  assign out_valid = (fq_count != '0);
  assign pop       = out_valid & out_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push      = (state_q == FETCH) & ~redirect_valid &
                     ((fq_count < CW'(FQ_DEPTH)) | pop);

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, lock_q;

  assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

  // lock_q keeps the FSM in HALT after a misaligned redirect; only an aligned
  // redirect clears it. err_q is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      lock_q <= 1'b0;
    end else if (redirect_valid) begin
      lock_q <= misaligned;
      if (misaligned) begin
        err_q <= 1'b1;
      end
    end
  end

  assign lock         = lock_q;
  assign misalign_err = err_q;
`else
  assign misaligned   = 1'b0;
  assign lock         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'h0000_0003;
      state_d = misaligned ? HALT : FETCH;
    end else begin
      if (push) begin
        pc_d = pc_q + PC_INC;
      end
      if (state_q == FETCH) begin
        if (halt) begin
          state_d = HALT;
        end
      end else begin
        if (!halt && !lock) begin
          state_d = FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign push_entry = '{pc: pc_q, instr: imem_data};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fq_count)
  );

  assign imem_addr = pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  fq_count;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory word i holds 32'h1000_0000 + i.
  assign imem_data = 32'h1000_0000 + (imem_addr >> 2);

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fq_count       (fq_count),
    .misalign_err   (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_fq_count", 32'(fq_count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // Streaming from reset, one instruction per cycle
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", out_pc, 32'(4 * (k - 1)));
      check("stream_instr", out_instr, 32'h1000_0000 + 32'(k - 1));
      check("stream_count", 32'(fq_count), 32'd1);
    end
    check("stream_addr", imem_addr, 32'h10);

    // Backpressure from a fresh reset: queue fills to 4 and stops
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("bp_count", 32'(fq_count), 32'd4);
    check("bp_addr", imem_addr, 32'h10);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_head_instr", out_instr, 32'h1000_0000);
    out_ready = 1'b1;
    #1;
    check("rel_pc0", out_pc, 32'h0);
    tick();
    check("rel_pc4", out_pc, 32'h4);
    check("rel_full_count", 32'(fq_count), 32'd4);
    tick();
    check("rel_pc8", out_pc, 32'h8);
    tick();
    check("rel_pcC", out_pc, 32'hC);
    check("rel_instrC", out_instr, 32'h1000_0003);
    check("rel_addr", imem_addr, 32'h1C);

    // Redirect to 0x40 while full and draining
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid0", 32'(out_valid), 32'd0);
    check("redir_count0", 32'(fq_count), 32'd0);
    check("redir_addr", imem_addr, 32'h40);
    tick();
    check("redir_valid1", 32'(out_valid), 32'd1);
    check("redir_pc", out_pc, 32'h40);
    check("redir_instr", out_instr, 32'h1000_0010);

    // Halt for 5 cycles: one last fetch on the transition edge, then drain
    halt = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("halt_count", 32'(fq_count), 32'd0);
    check("halt_valid", 32'(out_valid), 32'd0);
    check("halt_addr", imem_addr, 32'h48);
    halt = 1'b0;
    tick();
    check("unhalt_count", 32'(fq_count), 32'd0);
    tick();
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_pc", out_pc, 32'h48);
    check("resume_instr", out_instr, 32'h1000_0012);

    // Misaligned redirect to 0x42
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("mis_addr", imem_addr, 32'h40);
    check("mis_count", 32'(fq_count), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_err", 32'(misalign_err), 32'd1);
    for (int k = 0; k < 3; k++) tick();
    check("mis_held_addr", imem_addr, 32'h40);
    check("mis_held_valid", 32'(out_valid), 32'd0);
`else
    check("mis_err", 32'(misalign_err), 32'd0);
    tick();
    check("mis_cont_valid", 32'(out_valid), 32'd1);
    check("mis_cont_pc", out_pc, 32'h40);
`endif

    // Aligned redirect to 0x80 resumes fetch in both builds
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("r80_addr", imem_addr, 32'h80);
    tick();
    check("r80_valid", 32'(out_valid), 32'd1);
    check("r80_pc", out_pc, 32'h80);
    check("r80_instr", out_instr, 32'h1000_0020);
`ifdef FETCH_ALIGN_CHECK_EN
    check("r80_err_sticky", 32'(misalign_err), 32'd1);
`else
    check("r80_err", 32'(misalign_err), 32'd0);
`endif

    // Reset mid-stream with the queue half full
    out_ready = 1'b0;
    tick();
    check("half_count", 32'(fq_count), 32'd2);
    rst = 1'b1;
    tick();
    check("mid_rst_count", 32'(fq_count), 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err", 32'(misalign_err), 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller sitting between the PC logic and the combinationally read instruction memory (`addr` in, `data` out, word index `addr>>2`). It owns the program counter, sequences one word fetch per cycle into a small fetch queue, and presents instructions to decode with a valid/ready handshake. It also handles branch/jump redirects (flush plus new PC) and a halt request from the core.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `FQ_DEPTH`, default 4: fetch queue entries; power of 2, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  byte address to the instruction memory; equals the current PC.
- `imem_data`  in  32  instruction word returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  redirect request from execute.
- `redirect_pc`  in  32  redirect target.
- `halt`  in  1  level request to stop fetching.
- `out_valid`  out  1  queue head holds a valid instruction.
- `out_instr`  out  32  head instruction word.
- `out_pc`  out  32  PC of the head instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `fq_count`  out  $clog2(FQ_DEPTH)+1  current queue occupancy.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- `pop = out_valid & out_ready`.
- `push = (state==FETCH) & !redirect_valid & (fq_count<FQ_DEPTH | pop)`.
- On push:
  - enqueue {pc, `imem_data`};
  - pc <= pc + 4, wrapping modulo 2^32.
- The memory wraps its own index; the controller does not.
- A push and a pop in the same cycle leave `fq_count` unchanged; this is legal when the queue is full.
- On redirect (priority over everything except `rst`):
  - queue flushed, `fq_count` <= 0;
  - pc <= `redirect_pc` with [1:0] forced to 00;
  - no push that cycle;
  - a concurrent pop is still a completed handshake from decode's side.
- FSM states FETCH and HALT:
  - FETCH -> HALT when `halt`=1 and no redirect;
  - HALT -> FETCH when `halt`=0, or on redirect (the redirect wins and fetch resumes at the target even if `halt` stays high for one cycle, then re-halts).
- In HALT: no pushes; the queue keeps draining through pops.
- `out_valid = (fq_count != 0)`; `out_instr` and `out_pc` come from the registered head entry.
- Head fields are don't-care when `out_valid`=0 but must not be X after reset (storage cleared).

## Timing
- Reset values:
  - pc = `RESET_PC`, so `imem_addr` = `RESET_PC`;
  - state FETCH, `fq_count` 0, `out_valid` 0;
  - `out_instr` 0, `out_pc` 0, `misalign_err` 0.
- First cycle after `rst` falls: push of the word at `RESET_PC`. Cycle +1: `out_valid`=1 with that word. Fetch-to-decode latency is 1 cycle.
- Redirect at cycle N:
  - `out_valid`=0 at N+1, with `imem_addr`=target;
  - target instruction is valid at N+2.
- `rst` mid-operation discards the queue and all state in the same edge.
- Throughput: one instruction per cycle sustained while `out_ready`=1.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - a redirect with `redirect_pc[1:0]!=0` still flushes and loads the aligned PC;
  - it sets `misalign_err`=1 (sticky until `rst`) and forces state HALT;
  - only a later aligned redirect returns the FSM to FETCH.
- Not defined: low bits are silently cleared, `misalign_err` is tied 0, and no halt occurs.
- The port list is identical in both builds.

## Structure
- Package `fetch_pkg` holds:
  - `INSTR_W`=32, `PC_INC`=4;
  - `fq_entry_t` struct {pc, instr};
  - `fetch_state_e` enum {FETCH, HALT}.
- Sub-module `fetch_queue`: a circular FIFO of `fq_entry_t` with push, pop, flush and count outputs; wrap-around pointers are $clog2(FQ_DEPTH) bits.
- `fetch_ctrl` keeps the PC, the FSM and the redirect/alignment logic.

## Test plan
- Reset release with `out_ready`=1, memory word i = 32'h1000_0000+i: `out_pc` sequence 0,4,8,… from cycle 1, one per cycle, `out_instr` matching.
- `out_ready`=0 for 10 cycles: `fq_count` saturates at 4, `imem_addr` holds 32'h10, no overwrite; on release, PCs 0,4,8,C come out in order.
- Redirect to 32'h40 while the queue is full and `out_ready`=1: next cycle `out_valid`=0 and `fq_count`=0; following cycle `out_pc`=32'h40.
- `halt` held 5 cycles: queue drains to 0 and the PC is frozen; on deassert, fetch resumes at the frozen PC.
- Redirect to 32'h42: with `FETCH_ALIGN_CHECK_EN`, `misalign_err`=1 and the FSM stays in HALT until a redirect to 32'h80; without the macro, fetch continues at 32'h40 and `misalign_err`=0.
- `rst` asserted mid-stream with the queue half full: next cycle `fq_count`=0 and `imem_addr`=`RESET_PC`.
